// File: rtl/signed_pow2_divider_seq_pkg.sv
// signed_pow2_div_pkg: shared state encoding and rounding-mode constants for the divider
package signed_pow2_div_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic MODE_FLOOR = 1'b0;
  localparam logic MODE_TRUNC = 1'b1;
endpackage

// File: rtl/signed_pow2_divider_seq_if.sv
// signed_pow2_divider_seq_if: operand/result valid-ready channels of the divider
interface signed_pow2_divider_seq_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shift;
  logic          up_mode;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  modport master (
    output up_valid, up_data, up_shift, up_mode, down_ready,
    input  up_ready, down_valid, down_data
  );
  modport slave (
    input  up_valid, up_data, up_shift, up_mode, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

// File: rtl/signed_pow2_divider_seq_arith_shift.sv
// arith_shift_right_by_one: one-bit arithmetic right shift, exposing the bit dropped off the bottom
module arith_shift_right_by_one #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] res,
  output logic         shifted_out
);
  assign res         = {a[N-1], a[N-1:1]};
  assign shifted_out = a[0];
endmodule

// File: rtl/signed_pow2_divider_seq.sv
// signed_pow2_divider_seq: divides a signed operand by 2^k, one shift per cycle, floor or truncate
module signed_pow2_divider_seq
  import signed_pow2_div_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input logic                     clk,
  input logic                     rst_n,
  signed_pow2_divider_seq_if.slave bus
);
  state_t        state, state_nxt;
  logic [N-1:0]  acc, sh_res;
  logic [SW-1:0] cnt;
  logic          mode, sticky, sh_out, accept, last, corr;
  assign accept = bus.up_valid && state == IDLE;
  assign last   = state == SHIFT && cnt == SW'(1);
  assign corr   = mode == MODE_TRUNC && sh_res[N-1] && (sticky || sh_out);
  arith_shift_right_by_one #(.N(N)) u_shift (
    .a          (acc),
    .res        (sh_res),
    .shifted_out(sh_out)
  );
  // state register; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // next state: k = 0 skips straight to DONE, otherwise shift until the count runs out
  always_comb
    state_nxt = state == IDLE  ? (accept ? (bus.up_shift != '0 ? SHIFT : DONE) : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) :
                                 (bus.down_ready ? IDLE : DONE);
  // handshake outputs depend on state alone
  always_comb begin
    bus.up_ready   = state == IDLE;
    bus.down_valid = state == DONE;
  end
  // datapath: latch operand, shift with sticky capture, and register the corrected result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc           <= '0;
      cnt           <= '0;
      mode          <= 1'b0;
      sticky        <= 1'b0;
      bus.down_data <= '0;
    end else if (accept) begin
      acc    <= bus.up_data;
      cnt    <= bus.up_shift;
      mode   <= bus.up_mode;
      sticky <= 1'b0;
      if (bus.up_shift == '0) bus.down_data <= bus.up_data;
    end else if (state == SHIFT) begin
      acc    <= sh_res;
      sticky <= sticky | sh_out;
      cnt    <= cnt - SW'(1);
      if (last) bus.down_data <= sh_res + N'(corr);
    end
endmodule

// File: tb/tb_signed_pow2_divider_seq.sv
// tb_signed_pow2_divider_seq: directed table, corner sequences and randomized check against arithmetic reference
module tb_signed_pow2_divider_seq;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  signed_pow2_divider_seq_if #(.N(N)) bus ();
  signed_pow2_divider_seq #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [2:0] k;
    logic       m;
    logic [7:0] exp;
    int         lat;
  } vec_t;
  vec_t tbl[10];
  function automatic logic [7:0] ref_div(input logic [7:0] a, input int k, input logic m);
    int ai;
    ai = $signed(a);
    return m ? 8'(ai / (1 << k)) : 8'(ai >>> k);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic [7:0] a, input logic [2:0] k, input logic m, input int hold,
                       input bit noise, output logic [7:0] res, output int lat);
    bus.up_valid   = 1'b1;
    bus.up_data    = a;
    bus.up_shift   = k;
    bus.up_mode    = m;
    bus.down_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.up_valid = noise ? 1'($urandom) : 1'b0;
    bus.up_data  = 8'($urandom);
    bus.up_shift = 3'($urandom);
    bus.up_mode  = 1'($urandom);
    lat = 0;
    while (lat < 2 * N + 4) begin
      @(negedge clk);
      lat++;
      if (bus.down_valid) break;
    end
    if (!bus.down_valid) chk("down_valid_timeout", 32'(bus.down_valid), 1);
    res = bus.down_data;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", 32'(bus.down_data), 32'(res));
      chk("hold_valid", 32'(bus.down_valid), 1);
    end
    bus.down_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.down_ready = 1'b0;
    bus.up_valid   = 1'b0;
  endtask
  initial begin
    logic [7:0] res, a;
    logic [2:0] k;
    logic m;
    int lat, hold;
    tbl[0] = '{8'hF9, 3'd2, 1'b0, 8'hFE, 3};
    tbl[1] = '{8'hF9, 3'd2, 1'b1, 8'hFF, 3};
    tbl[2] = '{8'h64, 3'd3, 1'b0, 8'h0C, 4};
    tbl[3] = '{8'h64, 3'd3, 1'b1, 8'h0C, 4};
    tbl[4] = '{8'h80, 3'd7, 1'b0, 8'hFF, 8};
    tbl[5] = '{8'h80, 3'd7, 1'b1, 8'hFF, 8};
    tbl[6] = '{8'hFF, 3'd7, 1'b1, 8'h00, 8};
    tbl[7] = '{8'hFF, 3'd7, 1'b0, 8'hFF, 8};
    tbl[8] = '{8'hA5, 3'd0, 1'b0, 8'hA5, 1};
    tbl[9] = '{8'hA5, 3'd0, 1'b1, 8'hA5, 1};
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_shift   = '0;
    bus.up_mode    = 1'b0;
    bus.down_ready = 1'b0;
    #3;
    chk("rst_up_ready", 32'(bus.up_ready), 1);
    chk("rst_down_valid", 32'(bus.down_valid), 0);
    chk("rst_down_data", 32'(bus.down_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].a, tbl[i].k, tbl[i].m, 1, 1'b0, res, lat);
      chk($sformatf("tbl%0d_data", i), 32'(res), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end
    bus.up_valid = 1'b1;
    bus.up_data  = 8'hF9;
    bus.up_shift = 3'd2;
    bus.up_mode  = 1'b1;
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_valid", 32'(bus.down_valid), 1);
    chk("bp_data", 32'(bus.down_data), 32'h FF);
    for (int i = 0; i < 5; i++) begin
      bus.up_valid = 1'b1;
      bus.up_data  = 8'h11;
      bus.up_shift = 3'd0;
      @(negedge clk);
      chk("bp_stall_data", 32'(bus.down_data), 32'hFF);
      chk("bp_stall_up_ready", 32'(bus.up_ready), 0);
      chk("bp_stall_valid", 32'(bus.down_valid), 1);
    end
    bus.up_valid   = 1'b0;
    bus.down_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.down_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_up_ready", 32'(bus.up_ready), 1);
    chk("bp_idle_valid", 32'(bus.down_valid), 0);
    do_op(8'h64, 3'd3, 1'b0, 0, 1'b0, res, lat);
    chk("bp_next_data", 32'(res), 32'h0C);
    chk("bp_next_lat", 32'(lat), 4);
    bus.up_valid = 1'b1;
    bus.up_data  = 8'h80;
    bus.up_shift = 3'd7;
    bus.up_mode  = 1'b0;
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_in_shift", 32'(bus.up_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.down_valid), 0);
    chk("mid_rst_data", 32'(bus.down_data), 0);
    chk("mid_rst_up_ready", 32'(bus.up_ready), 1);
    @(negedge clk);
    chk("mid_rst_hold_valid", 32'(bus.down_valid), 0);
    chk("mid_rst_hold_data", 32'(bus.down_data), 0);
    rst_n = 1'b1;
    do_op(8'hF9, 3'd2, 1'b1, 2, 1'b0, res, lat);
    chk("post_rst_data", 32'(res), 32'hFF);
    chk("post_rst_lat", 32'(lat), 3);
    for (int i = 0; i < 10000; i++) begin
      a    = 8'($urandom);
      k    = 3'($urandom);
      m    = 1'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_op(a, k, m, hold, 1'b1, res, lat);
      chk($sformatf("rnd a=%0h k=%0d m=%0d data", a, k, m), 32'(res), 32'(ref_div(a, int'(k), m)));
      chk($sformatf("rnd a=%0h k=%0d lat", a, k), 32'(lat), 32'(int'(k) + 1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
